// File: rtl/sim_result_checker.sv
// Response monitor: accepts (index, golden) vectors, waits SETTLE_CYCLES, samples dut_out and accumulates results.
// Latency: SETTLE_CYCLES+2 cycles per sample; results visible the cycle after COMPARE.
// Backpressure: feedin_ready is high only in WAIT; the applied vector must be held until it returns high.
module sim_result_checker #(
    parameter int          T_IO_PAIRS    = 4,
    parameter int unsigned T_ITERATIONS  = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int         W             = 2 * T_IO_PAIRS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          feedin_valid,
    output logic          feedin_ready,
    input  logic [31:0]   feedin,
    input  logic [W-1:0]  expected,
    input  logic [W-1:0]  dut_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   mismatch_count,
    output logic [31:0]   sample_count,
    output logic [31:0]   first_fail_index,
    output logic [W-1:0]  first_fail_got,
    output logic [31:0]   signature
);

    typedef enum logic [2:0] {IDLE, WAIT, SETTLE, COMPARE, DONE} state_t;

    localparam logic [31:0] SETTLE_INIT = 32'(SETTLE_CYCLES);
    localparam logic [31:0] ITERS       = 32'(T_ITERATIONS);

    state_t         state;
    logic [31:0]    settle_cnt;
    logic [31:0]    index_q;
    logic [W-1:0]   expected_q;
    logic           miss;
    logic [31:0]    sample_next;

    assign miss        = (dut_out != expected_q);
    assign sample_next = sample_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            index_q          <= '0;
            expected_q       <= '0;
            feedin_ready     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            sample_count     <= '0;
            first_fail_index <= '0;
            first_fail_got   <= '0;
            signature        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= WAIT;
                        feedin_ready     <= 1'b1;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_count   <= '0;
                        sample_count     <= '0;
                        first_fail_index <= '0;
                        first_fail_got   <= '0;
                        signature        <= '0;
                    end
                end
                WAIT: begin
                    if (feedin_valid) begin
                        index_q      <= feedin;
                        expected_q   <= expected;
                        feedin_ready <= 1'b0;
                        settle_cnt   <= SETTLE_INIT;
                        state        <= (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 32'd1) begin
                        state <= COMPARE;
                    end
                    settle_cnt <= settle_cnt - 32'd1;
                end
                COMPARE: begin
                    signature    <= {signature[30:0], signature[31]} ^ 32'(dut_out);
                    sample_count <= sample_next;
                    if (miss) begin
                        if (mismatch_count != 16'hFFFF) begin
                            mismatch_count <= mismatch_count + 16'd1;
                        end
                        // A zero count means no earlier failure this run (the counter never wraps).
                        if (mismatch_count == 16'd0) begin
                            first_fail_index <= index_q;
                            first_fail_got   <= dut_out;
                        end
                    end
                    if (sample_next == ITERS) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_count == 16'd0) && !miss;
                    end else begin
                        state        <= WAIT;
                        feedin_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    feedin_ready <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_result_checker.sv
// Directed bench for sim_result_checker: a settle-2 instance for the main scenarios and a settle-0 instance.
module tb_sim_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        feedin_valid = 1'b0;
    logic        feedin_ready;
    logic [31:0] feedin = '0;
    logic [7:0]  expected = '0;
    logic [7:0]  dut_out = '0;
    logic        busy, done, pass;
    logic [15:0] mismatch_count;
    logic [31:0] sample_count, first_fail_index, signature;
    logic [7:0]  first_fail_got;

    logic        z_start = 1'b0;
    logic        z_valid = 1'b0;
    logic        z_ready;
    logic [31:0] z_feedin = '0;
    logic [7:0]  z_expected = 8'd7;
    logic [7:0]  z_dut_out = 8'd7;
    logic        z_busy, z_done, z_pass;
    logic [15:0] z_mismatch;
    logic [31:0] z_samples, z_ffi, z_sig;
    logic [7:0]  z_ffg;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sim_result_checker #(.T_IO_PAIRS(4), .T_ITERATIONS(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .feedin_valid(feedin_valid),
        .feedin_ready(feedin_ready), .feedin(feedin), .expected(expected), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
        .sample_count(sample_count), .first_fail_index(first_fail_index),
        .first_fail_got(first_fail_got), .signature(signature)
    );

    sim_result_checker #(.T_IO_PAIRS(4), .T_ITERATIONS(4), .SETTLE_CYCLES(0)) zdut (
        .clk(clk), .rst(rst), .start(z_start), .feedin_valid(z_valid),
        .feedin_ready(z_ready), .feedin(z_feedin), .expected(z_expected), .dut_out(z_dut_out),
        .busy(z_busy), .done(z_done), .pass(z_pass), .mismatch_count(z_mismatch),
        .sample_count(z_samples), .first_fail_index(z_ffi),
        .first_fail_got(z_ffg), .signature(z_sig)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All drive/poll points sit 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one vector, complete the handshake, optionally fix dut_out late, then wait for WAIT or DONE.
    task automatic drive_vec(input logic [31:0] idx, input logic [7:0] exp_v, input logic [7:0] early,
                             input logic [7:0] final_v, input int delay, input bit poke_start);
        int n;
        feedin = idx; expected = exp_v; dut_out = early; feedin_valid = 1'b1;
        n = 0;
        while (!feedin_ready && n < 50) begin @(posedge clk); #1; n++; end
        compared++;
        if (n >= 50) begin mismatched++; $display("FAIL ready_timeout idx=%0d got ready=%b want 1", idx, feedin_ready); end
        @(posedge clk); #1;
        if (poke_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            compared++;
            if (sample_count !== idx) begin mismatched++; $display("FAIL start_in_settle_count got %0d want %0d", sample_count, idx); end
            compared++;
            if ({feedin_ready, busy} !== 2'b01) begin mismatched++; $display("FAIL start_in_settle_state got ready/busy=%b want 01", {feedin_ready, busy}); end
        end
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1 dut_out = final_v;
        end
        n = 0;
        while (!feedin_ready && !done && n < 50) begin @(posedge clk); #1; n++; end
        compared++;
        if (n >= 50) begin mismatched++; $display("FAIL return_timeout idx=%0d got ready=%b done=%b want either 1", idx, feedin_ready, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            start = 1'($urandom); feedin_valid = 1'($urandom);
            feedin = $urandom; expected = 8'($urandom); dut_out = 8'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; feedin_valid = 1'b1;
        compared++;
        if ({feedin_ready, busy, done, pass, mismatch_count, sample_count, first_fail_index, first_fail_got, signature} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got ready=%b busy=%b done=%b pass=%b mc=%0d sc=%0d ffi=%0d ffg=%h sig=%h want all 0",
                     feedin_ready, busy, done, pass, mismatch_count, sample_count, first_fail_index, first_fail_got, signature);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            compared++;
            if (feedin_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready_idle cycle=%0d got %b want 0", k, feedin_ready); end
        end
        feedin_valid = 1'b0;
    endtask

    task automatic test_all_match();
        int c0;
        feedin = 0; expected = 0; dut_out = 0; feedin_valid = 1'b1;
        pulse_start();
        c0 = cyc;
        for (int i = 0; i < 4; i++) drive_vec(i, 8'(i), 8'(i), 8'(i), 0, 1'b0);
        // Rising edges counted from the start edge inclusive to the edge after which done is high.
        compared++;
        if (cyc - c0 + 1 !== 17) begin mismatched++; $display("FAIL done_latency got %0d want 17", cyc - c0 + 1); end
        feedin_valid = 1'b0;
        compared++;
        if ({done, pass} !== 2'b11) begin mismatched++; $display("FAIL match_done_pass got %b want 11", {done, pass}); end
        compared++;
        if (mismatch_count !== 16'd0) begin mismatched++; $display("FAIL match_mc got %0d want 0", mismatch_count); end
        compared++;
        if (sample_count !== 32'd4) begin mismatched++; $display("FAIL match_sc got %0d want 4", sample_count); end
        compared++;
        if (signature !== 32'h3) begin mismatched++; $display("FAIL match_sig got %h want 00000003", signature); end
    endtask

    task automatic test_first_fail();
        logic [7:0] got [4] = '{8'd0, 8'd1, 8'd5, 8'd9};
        pulse_start();
        for (int i = 0; i < 4; i++) drive_vec(i, 8'(i), got[i], got[i], 0, 1'b0);
        feedin_valid = 1'b0;
        compared++;
        if (mismatch_count !== 16'd2) begin mismatched++; $display("FAIL ff_mc got %0d want 2", mismatch_count); end
        compared++;
        if (first_fail_index !== 32'd2) begin mismatched++; $display("FAIL ff_index got %0d want 2", first_fail_index); end
        compared++;
        if (first_fail_got !== 8'h05) begin mismatched++; $display("FAIL ff_got got %h want 05", first_fail_got); end
        compared++;
        if ({done, pass} !== 2'b10) begin mismatched++; $display("FAIL ff_done_pass got %b want 10", {done, pass}); end
        compared++;
        if (signature !== 32'h7) begin mismatched++; $display("FAIL ff_sig got %h want 00000007", signature); end
    endtask

    task automatic test_restart_in_done();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({done, mismatch_count} !== {1'b1, 16'd2}) begin mismatched++; $display("FAIL done_hold got done=%b mc=%0d want 1/2", done, mismatch_count); end
        pulse_start();
        compared++;
        if ({mismatch_count, sample_count, first_fail_index, first_fail_got, signature} !== '0) begin
            mismatched++;
            $display("FAIL restart_clear got mc=%0d sc=%0d ffi=%0d ffg=%h sig=%h want all 0",
                     mismatch_count, sample_count, first_fail_index, first_fail_got, signature);
        end
        compared++;
        if ({feedin_ready, busy, done, pass} !== 4'b1100) begin mismatched++; $display("FAIL restart_flags got %b want 1100", {feedin_ready, busy, done, pass}); end
        for (int i = 0; i < 4; i++) drive_vec(32'(i + 10), 8'(i + 10), 8'(i + 10), 8'(i + 10), 0, 1'b0);
        feedin_valid = 1'b0;
        compared++;
        if ({done, pass, mismatch_count} !== {2'b11, 16'd0}) begin mismatched++; $display("FAIL restart_rerun got done/pass=%b mc=%0d want 11/0", {done, pass}, mismatch_count); end
    endtask

    task automatic test_settle_boundary();
        pulse_start();
        drive_vec(0, 8'd0, 8'hAA, 8'd0, 2, 1'b0);
        drive_vec(1, 8'd1, 8'hAA, 8'd1, 3, 1'b0);
        drive_vec(2, 8'd2, 8'd2, 8'd2, 0, 1'b0);
        drive_vec(3, 8'd3, 8'd3, 8'd3, 0, 1'b0);
        feedin_valid = 1'b0;
        compared++;
        if (mismatch_count !== 16'd1) begin mismatched++; $display("FAIL settle_mc got %0d want 1", mismatch_count); end
        compared++;
        if ({first_fail_index, first_fail_got} !== {32'd1, 8'hAA}) begin mismatched++; $display("FAIL settle_ff got idx=%0d val=%h want 1/aa", first_fail_index, first_fail_got); end
        compared++;
        if (signature !== 32'h2AF) begin mismatched++; $display("FAIL settle_sig got %h want 000002af", signature); end
    endtask

    task automatic test_start_in_settle();
        pulse_start();
        drive_vec(0, 8'd4, 8'd4, 8'd4, 0, 1'b0);
        drive_vec(1, 8'd5, 8'd5, 8'd5, 0, 1'b1);
        drive_vec(2, 8'd6, 8'd6, 8'd6, 0, 1'b0);
        drive_vec(3, 8'd7, 8'd7, 8'd7, 0, 1'b0);
        feedin_valid = 1'b0;
        compared++;
        if ({done, pass, sample_count} !== {2'b11, 32'd4}) begin mismatched++; $display("FAIL start_settle_final got done/pass=%b sc=%0d want 11/4", {done, pass}, sample_count); end
    endtask

    task automatic test_reset_in_compare();
        pulse_start();
        drive_vec(0, 8'd0, 8'd5, 8'd5, 0, 1'b0);
        drive_vec(1, 8'd1, 8'd1, 8'd1, 0, 1'b0);
        feedin = 2; expected = 8'd2; dut_out = 8'd2; feedin_valid = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({busy, feedin_ready, mismatch_count} !== {2'b10, 16'd1}) begin mismatched++; $display("FAIL pre_reset got busy/ready=%b mc=%0d want 10/1", {busy, feedin_ready}, mismatch_count); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; feedin_valid = 1'b0;
        compared++;
        if ({feedin_ready, busy, done, pass, mismatch_count, sample_count, first_fail_index, first_fail_got, signature} !== '0) begin
            mismatched++;
            $display("FAIL reset_in_compare got ready=%b busy=%b done=%b pass=%b mc=%0d sc=%0d ffi=%0d ffg=%h sig=%h want all 0",
                     feedin_ready, busy, done, pass, mismatch_count, sample_count, first_fail_index, first_fail_got, signature);
        end
    endtask

    task automatic test_zero_settle();
        int donek;
        z_valid = 1'b1; z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0;
        donek = 0;
        compared++;
        if (z_ready !== 1'b1) begin mismatched++; $display("FAIL zero_ready edge=1 got %b want 1", z_ready); end
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k <= 8) begin
                compared++;
                if (z_ready !== 1'(k % 2)) begin mismatched++; $display("FAIL zero_ready edge=%0d got %b want %b", k, z_ready, 1'(k % 2)); end
            end
            if (z_done && donek == 0) donek = k;
        end
        z_valid = 1'b0;
        compared++;
        if (donek !== 9) begin mismatched++; $display("FAIL zero_done_latency got %0d want 9", donek); end
        compared++;
        if ({z_pass, z_samples, z_sig} !== {1'b1, 32'd4, 32'h2D}) begin mismatched++; $display("FAIL zero_results got pass=%b sc=%0d sig=%h want 1/4/0000002d", z_pass, z_samples, z_sig); end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_first_fail();
        test_restart_in_done();
        test_settle_boundary();
        test_start_in_settle();
        test_reset_in_compare();
        test_zero_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
